// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the program ROM and feeds decode via a 2-entry queue.
// Optional build macro FETCH_SEQUENCER_PERF_EN adds saturating stall/redirect counters.
module fetch_sequencer #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Rom_Address,
  input  logic [DATA_WIDTH-1:0] Rom_Instruction,
  input  logic                  Redirect_Valid,
  input  logic [DATA_WIDTH-1:0] Redirect_PC,
  output logic                  Fetch_Valid,
  input  logic                  Fetch_Ready,
  output logic [DATA_WIDTH-1:0] Fetch_Instruction,
  output logic [DATA_WIDTH-1:0] Fetch_PC,
`ifdef FETCH_SEQUENCER_PERF_EN
  output logic [31:0]           Perf_Stall_Count,
  output logic [31:0]           Perf_Redirect_Count,
`endif
  output logic                  Fetch_Fault
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  fault;
  } entry_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [DATA_WIDTH-1:0] TEXT_END =
    RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            count_q, count_d;
  entry_t                slot0_q, slot0_d;
  entry_t                slot1_q, slot1_d;

  logic [DATA_WIDTH-1:0] fetch_addr;
  logic                  fetch_fault;
  logic                  can_fetch;
  logic                  pop;
  logic                  push;
  entry_t                new_entry;

  always_comb begin
    fetch_addr  = Redirect_Valid ? Redirect_PC : pc_q;
    fetch_fault = (fetch_addr < RESET_PC) ||
                  (fetch_addr >= TEXT_END) ||
                  (fetch_addr[1:0] != 2'b00);
    new_entry.pc    = fetch_addr;
    new_entry.instr = fetch_fault ? '0 : Rom_Instruction;
    new_entry.fault = fetch_fault;
  end

  assign Rom_Address = fetch_addr - RESET_PC;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (push) state_d = fetch_fault ? HALT : RUN;
  end

  always_comb begin
    can_fetch = (state_q == RUN);
  end

  // A redirect voids the handshake and always pushes its target.
  assign pop  = (count_q != 2'd0) && Fetch_Ready && !Redirect_Valid;
  assign push = Redirect_Valid ||
                (can_fetch && ((count_q != 2'd2) || pop));

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    pc_d    = pc_q;
    if (Redirect_Valid) begin
      slot0_d = new_entry;
      count_d = 2'd1;
    end else begin
      if (pop) begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      if (push) begin
        if (count_d == 2'd0) slot0_d = new_entry;
        else                 slot1_d = new_entry;
        count_d = count_d + 2'd1;
      end
    end
    if (push) pc_d = fetch_addr + DATA_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign Fetch_Valid       = (count_q != 2'd0);
  assign Fetch_PC          = slot0_q.pc;
  assign Fetch_Instruction = slot0_q.instr;
  assign Fetch_Fault       = slot0_q.fault;

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (can_fetch && (count_q == 2'd2) && !pop &&
        (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (Redirect_Valid && (redir_cnt_q != 32'hFFFF_FFFF))
      redir_cnt_d = redir_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign Perf_Stall_Count    = stall_cnt_q;
  assign Perf_Redirect_Count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reference model predicts every
// queue push; entries are compared as they reach the head of the queue.
module tb_fetch_sequencer;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Rom_Address;
  logic [31:0] Rom_Instruction;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_PC = '0;
  logic        Fetch_Valid;
  logic        Fetch_Ready = 1'b0;
  logic [31:0] Fetch_Instruction;
  logic [31:0] Fetch_PC;
  logic        Fetch_Fault;
`ifdef FETCH_SEQUENCER_PERF_EN
  logic [31:0] Perf_Stall_Count;
  logic [31:0] Perf_Redirect_Count;
  logic [31:0] m_stall;
  logic [31:0] m_redir;
`endif

  exp_t        sb[$];
  logic [31:0] mpc;
  bit          mhalt;
  int          vectors = 0;
  int          miscompares = 0;

  fetch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .Rom_Address       (Rom_Address),
    .Rom_Instruction   (Rom_Instruction),
    .Redirect_Valid    (Redirect_Valid),
    .Redirect_PC       (Redirect_PC),
    .Fetch_Valid       (Fetch_Valid),
    .Fetch_Ready       (Fetch_Ready),
    .Fetch_Instruction (Fetch_Instruction),
    .Fetch_PC          (Fetch_PC),
`ifdef FETCH_SEQUENCER_PERF_EN
    .Perf_Stall_Count    (Perf_Stall_Count),
    .Perf_Redirect_Count (Perf_Redirect_Count),
`endif
    .Fetch_Fault       (Fetch_Fault)
  );

  always #5 clk = ~clk;

  // 32-word ROM holding 0x20080001 + word index; garbage outside it.
  assign Rom_Instruction = (Rom_Address < 32'd128) ?
    32'h2008_0001 + (Rom_Address >> 2) : 32'hDEAD_BEEF;

  function automatic bit is_fault(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'd128) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h2008_0001 + ((a - BASE) >> 2);
  endfunction

  task automatic step(input bit redir, input logic [31:0] rpc,
                      input bit rdy, input string tag);
    bit          pop;
    bit          push;
    logic [31:0] fa;
    exp_t        e;
    @(negedge clk);
    reset          = 1'b1;
    Redirect_Valid = redir;
    Redirect_PC    = rpc;
    Fetch_Ready    = rdy;
    #1;
    vectors++;
    if (Fetch_Valid !== (sb.size() != 0)) begin
      miscompares++;
      $display("FAIL %s valid: got %b want %b", tag, Fetch_Valid,
               sb.size() != 0);
    end
    if (sb.size() != 0) begin
      vectors++;
      if ({Fetch_PC, Fetch_Instruction, Fetch_Fault} !== sb[0]) begin
        miscompares++;
        $display("FAIL %s head: got pc=%h ins=%h flt=%b want pc=%h ins=%h flt=%b",
                 tag, Fetch_PC, Fetch_Instruction, Fetch_Fault,
                 sb[0].pc, sb[0].instr, sb[0].fault);
      end
    end
    fa = redir ? rpc : mpc;
    vectors++;
    if (Rom_Address !== fa - BASE) begin
      miscompares++;
      $display("FAIL %s rom_addr: got %h want %h", tag, Rom_Address,
               fa - BASE);
    end
    pop = (sb.size() != 0) && rdy && !redir;
`ifdef FETCH_SEQUENCER_PERF_EN
    vectors++;
    if (Perf_Stall_Count !== m_stall || Perf_Redirect_Count !== m_redir) begin
      miscompares++;
      $display("FAIL %s perf: got %0d/%0d want %0d/%0d", tag,
               Perf_Stall_Count, Perf_Redirect_Count, m_stall, m_redir);
    end
    if (!mhalt && sb.size() == 2 && !pop) m_stall++;
    if (redir) m_redir++;
`endif
    push = redir || (!mhalt && (sb.size() < 2 || pop));
    if (redir)    sb.delete();
    else if (pop) void'(sb.pop_front());
    if (push) begin
      e.pc    = fa;
      e.fault = is_fault(fa);
      e.instr = e.fault ? 32'h0 : rom_word(fa);
      sb.push_back(e);
      mpc   = fa + 32'd4;
      mhalt = e.fault;
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input bit redir, input logic [31:0] rpc,
                          input bit rdy);
    @(negedge clk);
    reset          = 1'b0;
    Redirect_Valid = redir;
    Redirect_PC    = rpc;
    Fetch_Ready    = rdy;
    @(posedge clk);
    sb.delete();
    mpc   = BASE;
    mhalt = 1'b0;
`ifdef FETCH_SEQUENCER_PERF_EN
    m_stall = '0;
    m_redir = '0;
`endif
    Redirect_Valid = 1'b0;
    #1;
    vectors++;
    if ({Fetch_Valid, Fetch_PC, Fetch_Instruction, Fetch_Fault} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset outs: got v=%b pc=%h ins=%h flt=%b want all 0",
               Fetch_Valid, Fetch_PC, Fetch_Instruction, Fetch_Fault);
    end
    vectors++;
    if (Rom_Address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset pc: got rom_addr %h want 00000000", Rom_Address);
    end
`ifdef FETCH_SEQUENCER_PERF_EN
    vectors++;
    if (Perf_Stall_Count !== 32'd0 || Perf_Redirect_Count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset perf: got %0d/%0d want 0/0",
               Perf_Stall_Count, Perf_Redirect_Count);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_stream();
    do_reset(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, "stream");
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, "stall");
    #1;
    vectors++;
    if (Rom_Address !== 32'h8 || Fetch_PC !== BASE) begin
      miscompares++;
      $display("FAIL stall hold: got rom_addr=%h pc=%h want 00000008 %h",
               Rom_Address, Fetch_PC, BASE);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, "release");
  endtask

  task automatic test_redirect_full();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, "fill");
    step(1'b1, BASE + 32'h10, 1'b1, "redir_full");
    #1;
    vectors++;
    if (Fetch_PC !== BASE + 32'h10 || Fetch_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL redir latency: got v=%b pc=%h want 1 %h",
               Fetch_Valid, Fetch_PC, BASE + 32'h10);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "after_redir");
  endtask

  task automatic test_end_of_text();
    step(1'b1, BASE + 32'h70, 1'b1, "eot_redir");
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b1, "eot_run");
    #1;
    vectors++;
    if (Fetch_Valid !== 1'b0 || Rom_Address !== 32'h84) begin
      miscompares++;
      $display("FAIL eot halt: got v=%b rom_addr=%h want 0 00000084",
               Fetch_Valid, Rom_Address);
    end
    step(1'b1, BASE, 1'b1, "eot_resume");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, "eot_resumed");
  endtask

  task automatic test_bad_target();
    step(1'b1, BASE + 32'h6, 1'b1, "misalign");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, "misalign_halt");
    step(1'b1, 32'h003F_FFFC, 1'b0, "below_text");
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b0, "below_hold");
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, "below_drain");
    step(1'b1, BASE + 32'h4, 1'b1, "bad_resume");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, "bad_resumed");
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, "pre_rst");
    do_reset(1'b1, BASE + 32'h20, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "post_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      step(($urandom_range(0, 5) == 0), BASE + 32'(4 * $urandom_range(0, 33)),
           ($urandom_range(0, 2) != 0), "mixed");
  endtask

  initial begin
    mpc   = BASE;
    mhalt = 1'b0;
`ifdef FETCH_SEQUENCER_PERF_EN
    m_stall = '0;
    m_redir = '0;
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_end_of_text();
    test_bad_target();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the combinational program ROM for the MIPS core.
- Owns the PC and issues one ROM address per cycle.
- Buffers fetched {PC, instruction} pairs in a 2-entry queue toward decode, with a valid/ready handshake.
- Accepts branch/jump redirects and flags fetches outside the text segment.

Parameters:
- DATA_WIDTH, 32, width of PC, ROM address and instruction.
- MEMORY_DEPTH, 32, number of words in program ROM; defines text-segment size.
- RESET_PC, 32'h00400000, PC after reset; base of text segment.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Rom_Address  output  DATA_WIDTH  byte address to program ROM, relative to RESET_PC (ROM drops bits [1:0] itself).
- Rom_Instruction  input  DATA_WIDTH  combinational ROM read data for Rom_Address.
- Redirect_Valid  input  1  branch/jump taken this cycle.
- Redirect_PC  input  DATA_WIDTH  target PC for redirect.
- Fetch_Valid  output  1  queue head valid.
- Fetch_Ready  input  1  decode accepts head this cycle.
- Fetch_Instruction  output  DATA_WIDTH  head instruction.
- Fetch_PC  output  DATA_WIDTH  head PC.
- Fetch_Fault  output  1  head entry is an out-of-range or misaligned fetch.

Behaviour:
- Reset (clk edge with reset==0): PC=RESET_PC, queue emptied (count=0), state=RUN. Fetch_Valid=0, Fetch_Instruction=0, Fetch_PC=0, Fetch_Fault=0.
- The reset clock edge overrides every other event, including a redirect or handshake in that same cycle.
- Fetch address is combinational: FA = Redirect_Valid ? Redirect_PC : PC. Rom_Address = FA - RESET_PC (modulo 2^DATA_WIDTH).
- Fetch fault when FA < RESET_PC, FA >= RESET_PC + 4*MEMORY_DEPTH, or FA[1:0] != 0.
- Pop condition: Fetch_Valid & Fetch_Ready & ~Redirect_Valid.
- Push condition, state RUN: push when count<2, or when count==2 and a pop occurs in the same cycle. Simultaneous push and pop keeps the count unchanged.
- Push entry: {FA, Rom_Instruction, fault}. A faulted entry carries instruction 0 (NOP) and fault=1.
- Redirect (Redirect_Valid=1): queue flushed and any handshake that cycle is void. The entry for Redirect_PC is pushed in the same cycle (queue is empty after the flush). PC <= Redirect_PC+4. Fetch_Valid=1 with the target on the next cycle (1-cycle redirect latency).
- Non-redirect push: PC <= PC+4. PC holds when no push occurs.
- PC arithmetic is modulo 2^DATA_WIDTH.
- States:
  - RUN: normal fetch. Pushing a faulted entry -> HALT.
  - HALT: no pushes, PC frozen. Queue still drains via handshake. Redirect_Valid -> RUN, with the same-cycle push of the target (target may itself fault and remain in HALT).
- Last ROM word (RESET_PC+4*(MEMORY_DEPTH-1)) is fetched normally. The next sequential fetch faults -> HALT.
- Queue order is strict FIFO. Outputs are registered from the head entry. Fetch_Valid = (count != 0).
- Reset mid-stream discards all queued entries; no partial state survives.

Optional Feature:
- Macro: FETCH_SEQUENCER_PERF_EN.
- Defined: adds output Perf_Stall_Count (32 bits) and output Perf_Redirect_Count (32 bits), both 0 on reset.
  - Perf_Stall_Count increments each cycle in RUN where count==2 and no pop occurs.
  - Perf_Redirect_Count increments each cycle Redirect_Valid=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset then Fetch_Ready=1 constant, ROM words 0..3 = 0x20080001..0x20080004 -> Fetch_PC 0x00400000, 0x00400004, … on consecutive cycles starting 1 cycle after reset release, with matching instructions, Fetch_Fault=0.
- Fetch_Ready=0 for 5 cycles after reset -> count fills to 2. Fetch_Valid=1 holding PC 0x00400000 and the PC register frozen at 0x00400008. On release, 0x00400000, 0x00400004, 0x00400008 emerge in order with no gaps or duplicates.
- Queue full, redirect to 0x00400010 with Fetch_Ready=1 that cycle -> old head not consumed. Next cycle Fetch_PC=0x00400010, then 0x00400014.
- Sequential run past 0x0040007C (MEMORY_DEPTH=32) -> entry PC 0x00400080 with Fetch_Fault=1 and instruction 0. No further pushes until redirect to 0x00400000 resumes fetch.
- Redirect to 0x00400006 -> single faulted entry, state HALT. Redirect to 0x003FFFFC -> faulted entry.
- Assert reset low mid-stream with queue full and redirect active -> next cycle Fetch_Valid=0 and PC=0x00400000. With FETCH_SEQUENCER_PERF_EN defined, both counters read 0.
